// File: rtl/digit_sequence_detector.sv
// Detects the display sequence 8,3,0,8,2,4,3,5,1 in a strobed BCD digit stream.
// Optional strobe debouncing is enabled by defining DIGIT_DEBOUNCE_EN.
module digit_sequence_detector #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MATCH_CNT_W     = 4
) (
  input  logic                   PIN_Y2,
  input  logic                   SW0,
  input  logic [3:0]             digit_in,
  input  logic                   digit_strobe,
  output logic [3:0]             progress,
  output logic                   match,
  output logic [MATCH_CNT_W-1:0] match_count,
  output logic                   error,
  output logic [3:0]             output_z
);

  typedef enum logic [3:0] {
    K0, K1, K2, K3, K4, K5, K6, K7, K8, K9
  } state_t;

  localparam logic [3:0] BLANK = 4'b1010;

  state_t state;
  state_t state_next;
  logic   sync_a;
  logic   sync_b;
  logic   level;
  logic   level_prev;
  logic   accept;
  logic   digit_valid;
  logic   match_next;

  always_ff @(posedge PIN_Y2) begin
    if (SW0) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      level_prev <= 1'b0;
    end else begin
      sync_a     <= digit_strobe;
      sync_b     <= sync_a;
      level_prev <= level;
    end
  end

`ifdef DIGIT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] db_count;
  logic             db_level;

  // The debounced level only flips after the synchronized strobe has
  // disagreed with it for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge PIN_Y2) begin
    if (SW0) begin
      db_count <= '0;
      db_level <= 1'b0;
    end else if (sync_b != db_level) begin
      if (db_count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_count <= '0;
        db_level <= sync_b;
      end else begin
        db_count <= db_count + 1'b1;
      end
    end else begin
      db_count <= '0;
    end
  end

  assign level = db_level;
`else
  logic debounce_unused;
  assign debounce_unused = (DEBOUNCE_CYCLES != 0);
  assign level = sync_b;
`endif

  assign accept      = level & ~level_prev;
  assign digit_valid = (digit_in <= 4'd9);

  function automatic logic [3:0] expected_digit(input state_t k);
    case (k)
      K0:      expected_digit = 4'd8;
      K1:      expected_digit = 4'd3;
      K2:      expected_digit = 4'd0;
      K3:      expected_digit = 4'd8;
      K4:      expected_digit = 4'd2;
      K5:      expected_digit = 4'd4;
      K6:      expected_digit = 4'd3;
      K7:      expected_digit = 4'd5;
      K8:      expected_digit = 4'd1;
      default: expected_digit = 4'd15;
    endcase
  endfunction

  always_ff @(posedge PIN_Y2) begin
    if (SW0) begin
      state <= K0;
    end else begin
      state <= state_next;
    end
  end

  // On a mismatch fall back to the longest suffix that is also a prefix:
  // a trailing 8 restarts at K1, and "8,3,0,8,3" leaves "8,3" matched.
  always_comb begin
    state_next = state;
    if (accept) begin
      if (!digit_valid) begin
        state_next = K0;
      end else if (state != K9 && digit_in == expected_digit(state)) begin
        state_next = state_t'(state + 4'd1);
      end else if (digit_in == 4'd8) begin
        state_next = K1;
      end else if (state == K4 && digit_in == 4'd3) begin
        state_next = K2;
      end else begin
        state_next = K0;
      end
    end
  end

  always_comb begin
    progress   = 4'(state);
    match_next = accept && (state_next == K9);
  end

  always_ff @(posedge PIN_Y2) begin
    if (SW0) begin
      match       <= 1'b0;
      match_count <= '0;
      error       <= 1'b0;
      output_z    <= BLANK;
    end else begin
      match <= match_next;
      if (match_next && match_count != '1) begin
        match_count <= match_count + 1'b1;
      end
      if (accept) begin
        error    <= ~digit_valid;
        output_z <= digit_valid ? digit_in : BLANK;
      end
    end
  end

endmodule
